// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Multi-cycle MULT/DIV engine that owns the architectural HI/LO registers.
//   The control unit pulses start from its MULT/DIV states and holds there until
//   done. MULT uses radix-2 Booth on a 2*WIDTH+1 product register; DIV uses
//   restoring division on operand magnitudes with signs applied at the end.
//   Both run WIDTH iterations, one per cycle.
//
//   Optional build macro: MULTDIV_ZERO_SKIP_EN
//     defined   : MULT with a zero operand bypasses the iterations (done 1 cycle after start)
//     undefined : every MULT runs all WIDTH iterations
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high
//   start  in   request, accepted only when idle
//   op     in   0 = MULT (signed), 1 = DIV (signed)
//   a      in   WIDTH  multiplicand / dividend
//   b      in   WIDTH  multiplier / divisor
//   busy   out  operation in progress
//   done   out  one-cycle pulse, hi/lo valid
//   div0   out  one-cycle pulse with done on divide-by-zero
//   hi     out  WIDTH  MULT upper half / DIV remainder
//   lo     out  WIDTH  MULT lower half / DIV quotient
//
// state    | meaning
// IDLE     | waiting for start
// MULT_RUN | one Booth iteration per cycle
// DIV_RUN  | one restoring quotient bit per cycle
// FINISH   | write hi/lo, raise done on exit
// DIV_ZERO | divisor was zero; raise done+div0 on exit, hi/lo untouched

module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        FINISH   = 3'd3,
        DIV_ZERO = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   m_q;        // multiplicand, or divisor magnitude
    logic [2*WIDTH:0]   prod_q;     // {acc, multiplier, q(-1)}
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               neg_q;      // quotient negative
    logic               neg_r;      // remainder negative (follows dividend)

    logic               accept;
    logic               mult_zero;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     acc_x;
    logic [WIDTH:0]     m_x;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;

    // A start that coincides with the done pulse is dropped so the control
    // unit always sees done before a new operation can begin.
    assign accept    = (state_q == IDLE) && start && !done;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MULTDIV_ZERO_SKIP_EN
    assign mult_zero = (a == '0) || (b == '0);
`else
    assign mult_zero = 1'b0;
`endif

    // Magnitudes as unsigned; MIN_INT maps onto itself, which is correct unsigned.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Booth step: accumulate in WIDTH+1 bits so -MIN_INT cannot overflow,
    // then the arithmetic shift right drops straight out of the concatenation.
    assign acc_x = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    assign m_x   = {m_q[WIDTH-1], m_q};

    always_comb begin
        booth_sum = acc_x;
        case (prod_q[1:0])
            2'b01:   booth_sum = acc_x + m_x;
            2'b10:   booth_sum = acc_x - m_x;
            default: booth_sum = acc_x;
        endcase
    end

    // Restoring step: the difference is below the divisor whenever it is kept,
    // so WIDTH bits of it are enough.
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, m_q});
    assign div_sub   = div_shift[WIDTH-1:0] - m_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!op)            state_d = mult_zero ? FINISH : MULT_RUN;
                    else if (b == '0)   state_d = DIV_ZERO;
                    else                state_d = DIV_RUN;
                end
            end
            MULT_RUN: if (last_iter) state_d = FINISH;
            DIV_RUN:  if (last_iter) state_d = FINISH;
            FINISH:   state_d = IDLE;
            DIV_ZERO: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MULT_RUN) || (state_q == DIV_RUN) || (state_q == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            op_q   <= 1'b0;
            m_q    <= '0;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        if (!op) begin
                            m_q    <= a;
                            prod_q <= mult_zero ? '0 : {{WIDTH{1'b0}}, b, 1'b0};
                        end else begin
                            m_q   <= b_mag;
                            rem_q <= '0;
                            quo_q <= a_mag;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                        end
                    end
                end
                MULT_RUN: begin
                    prod_q <= {booth_sum, prod_q[WIDTH:1]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                DIV_RUN: begin
                    rem_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], div_ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    if (op_q) begin
                        hi <= neg_r ? -rem_q : rem_q;
                        lo <= neg_q ? -quo_q : quo_q;
                    end else begin
                        hi <= prod_q[2*WIDTH:WIDTH+1];
                        lo <= prod_q[WIDTH:1];
                    end
                end
                DIV_ZERO: begin
                    done <= 1'b1;
                    div0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    localparam int ML = 33;
`ifdef MULTDIV_ZERO_SKIP_EN
    localparam int ZL = 1;
`else
    localparam int ZL = 33;
`endif

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to done. glitch_at > 0 re-pulses start
    // with different operands that many cycles after acceptance.
    task automatic run_op(input string name, input logic op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_d0,
                          input int exp_lat, input int glitch_at);
        int   lat;
        logic got;
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_after_start"}, {31'b0, busy}, {31'b0, ~exp_d0});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (lat == 2 && exp_lat > 3) begin
                check({name, " hi_held"}, hi, prev_hi);
                check({name, " lo_held"}, lo, prev_lo);
            end
            @(posedge clk); #1;
            lat++;
            if (lat == glitch_at) begin
                start = 1'b1; op = ~op_i; a = a_i + 32'd5; b = 32'd3;
            end
            if (lat == glitch_at + 1) start = 1'b0;
            if (done) got = 1'b1;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        check({name, " div0"}, {31'b0, div0}, {31'b0, exp_d0});
        check({name, " busy_at_done"}, {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, {31'b0, done}, 32'h0);
        check({name, " div0_one_cycle"}, {31'b0, div0}, 32'h0);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    int   lat;
    logic got;
    int   seen_done;

    initial begin
        vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, ML};
        vecs[1]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, ML};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, ML};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, ML};
        vecs[4]  = '{1'b0, 32'd0,        32'd12345,    32'h00000000, 32'h00000000, ZL};
        vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ML};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, ML};
        vecs[7]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, ML};
        vecs[8]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, ML};
        vecs[9]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, ML};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, ML};
        vecs[11] = '{1'b1, 32'd3,        32'd10,       32'h00000003, 32'h00000000, ML};
        vecs[12] = '{1'b1, 32'h80000000, 32'd1,        32'h00000000, 32'h80000000, ML};
        vecs[13] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, ML};
        vecs[14] = '{1'b0, 32'd12345,    32'd0,        32'h00000000, 32'h00000000, ZL};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset div0", {31'b0, div0}, 32'h0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].lat, 0);
        end

        // divide-by-zero leaves a preloaded hi/lo untouched
        run_op("preload", 1'b0, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, ML, 0);
        run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 32'h0, 32'd81, 1'b1, 1, 0);

        // start re-pulsed mid-operation is ignored
        run_op("start_while_busy", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, ML, 10);

        // start held through the done cycle is taken one cycle later
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check("done_cycle first latency", 32'(lat), 32'(ML));
        check("done_cycle first lo", lo, 32'd15);
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        check("done_cycle start ignored busy", {31'b0, busy}, 32'h0);
        check("done_cycle no repeat done", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cycle start accepted busy", {31'b0, busy}, 32'h1);
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check("done_cycle second latency", 32'(lat), 32'(ML));
        check("done_cycle second hi", hi, 32'h0);
        check("done_cycle second lo", lo, 32'd6);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd11; b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_reset busy", {31'b0, busy}, 32'h0);
        check("mid_reset done", {31'b0, done}, 32'h0);
        check("mid_reset div0", {31'b0, div0}, 32'h0);
        check("mid_reset hi", hi, 32'h0);
        check("mid_reset lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("mid_reset no done pulse", 32'(seen_done), 32'h0);
        prev_hi = 32'h0;
        prev_lo = 32'h0;

        run_op("after_reset", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, ML, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
